// File: rtl/bram_arb.sv
// Arbiter/sequencer sharing one single-port block RAM between instruction fetch
// and load/store, with a bounded-wait guard so fetch cannot be starved.
module bram_arb #(
   parameter int XW      = 32,
   parameter int WS      = XW / 8,
   parameter int MAXWAIT = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          creq,
   input  logic [XW-1:0] cadrs_i,
   output logic          cack,
   output logic [XW-1:0] cdata,
   output logic          cerr,
   input  logic          dreq,
   input  logic          drd_i,
   input  logic          dwe_i,
   input  logic [WS-1:0] dwst_i,
   input  logic [XW-1:0] dadrs_i,
   input  logic [XW-1:0] din_i,
   output logic          dack,
   output logic [XW-1:0] ddata,
   output logic          derr,
   output logic          ccs,
   output logic          dcs,
   output logic          drd,
   output logic          dwe,
   output logic [WS-1:0] dwst,
   output logic [XW-1:0] cadrs,
   output logic [XW-1:0] dadrs,
   output logic [XW-1:0] din,
   input  logic [XW-1:0] ram_dout,
   input  logic          ram_irq
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CFLT = 2'd1,
      DFLT = 2'd2
   } state_t;

   localparam logic [3:0] MAXW = 4'(MAXWAIT);

   state_t        state_q, state_d;
   logic [3:0]    cwait_q, cwait_d;
   logic          cack_q, dack_q, cerr_q, derr_q;
   logic [XW-1:0] cadrs_q, dadrs_q, din_q;
   logic          c_elig, d_elig, c_win, d_win;

   // The requester in flight is masked: its req stays high through its ack cycle.
   always_comb begin
      c_elig  = creq && !rst && (state_q != CFLT);
      d_elig  = dreq && !rst && (state_q != DFLT);
      c_win   = c_elig && (!d_elig || (cwait_q >= MAXW));
      d_win   = d_elig && !c_win;
      state_d = c_win ? CFLT : (d_win ? DFLT : IDLE);
      cwait_d = cwait_q;
      if (!creq || c_win) begin
         cwait_d = '0;
      end else if ((state_q != CFLT) && (cwait_q != 4'hF)) begin
         cwait_d = cwait_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cwait_q <= '0;
         cack_q  <= 1'b0;
         dack_q  <= 1'b0;
         cerr_q  <= 1'b0;
         derr_q  <= 1'b0;
         cadrs_q <= '0;
         dadrs_q <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         cwait_q <= cwait_d;
         cack_q  <= c_win;
         dack_q  <= d_win;
         cerr_q  <= c_win & ram_irq;
         derr_q  <= d_win & ram_irq;
         if (c_win) begin
            cadrs_q <= cadrs_i;
         end
         if (d_win) begin
            dadrs_q <= dadrs_i;
            din_q   <= din_i;
         end
      end
   end

   // RAM controls are issued in the request cycle; buses hold their last value when idle.
   assign ccs   = c_win;
   assign dcs   = d_win;
   assign drd   = d_win & drd_i;
   assign dwe   = d_win & dwe_i;
   assign dwst  = d_win ? dwst_i : '0;
   assign cadrs = c_win ? cadrs_i : cadrs_q;
   assign dadrs = d_win ? dadrs_i : dadrs_q;
   assign din   = d_win ? din_i : din_q;

   assign cack  = cack_q;
   assign dack  = dack_q;
   assign cerr  = cerr_q;
   assign derr  = derr_q;
   assign cdata = cack_q ? ram_dout : '0;
   assign ddata = dack_q ? ram_dout : '0;

endmodule
